// File: rtl/aes_pkg.sv
// Shared AES-128 types, state encoding, S-box and round-constant helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package aes_pkg;

  localparam int AES_KEY_W     = 128;
  localparam int AES128_ROUNDS = 10;

  typedef logic [AES_KEY_W-1:0] aes_key_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_e;

  // Forward AES S-box; entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Round constants for AES-128; only indices 0..9 are ever used.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_keygen.sv
// One AES-128 key-expansion step: next round key from previous round key and rcon index.
// Latency: purely combinational.
// Backpressure: none.
module keyGen
  import aes_pkg::*;
(
  input  logic [3:0] rc_i,
  input  aes_key_t   key_i,
  output aes_key_t   key_o
);

  logic [31:0] w0, w1, w2, w3, t;

  assign w0 = key_i[127:96];
  assign w1 = key_i[95:64];
  assign w2 = key_i[63:32];
  assign w3 = key_i[31:0];

  // RotWord, SubWord, then fold in the round constant on the top byte.
  assign t = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rc_i), 24'h0};

  assign key_o[127:96] = w0 ^ t;
  assign key_o[95:64]  = w0 ^ t ^ w1;
  assign key_o[63:32]  = w0 ^ t ^ w1 ^ w2;
  assign key_o[31:0]   = w0 ^ t ^ w1 ^ w2 ^ w3;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Sequences keyGen once per clock to fill a bank with the cipher key and all round keys.
// Latency: key_ready NUM_ROUNDS cycles after an accepted start; read port is 1 cycle.
// Backpressure: none; starts during expansion are dropped, starts otherwise always accepted.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_start,
  input  logic [127:0]   key_in,
  output logic           key_busy,
  output logic           key_ready,
  input  logic [3:0]     rd_round,
  output logic [127:0]   rd_key
);

  state_e     state_q, state_d;
  logic [3:0] rc_q, rc_d;
  aes_key_t   work_q, work_d;
  aes_key_t   bank_q [0:NUM_ROUNDS];
  aes_key_t   gen_key;
  aes_key_t   rd_mux;
  aes_key_t   rd_key_q;
  logic       load;
  logic       step;

  keyGen u_keygen (
    .rc_i  (rc_q),
    .key_i (work_q),
    .key_o (gen_key)
  );

  // Next-state: load on start from IDLE/READY, then one keyGen step per cycle.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    work_d  = work_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (key_start) begin
          state_d = EXPAND;
          rc_d    = 4'd0;
          work_d  = key_in;
          load    = 1'b1;
        end
      end
      EXPAND: begin
        step   = 1'b1;
        rc_d   = rc_q + 4'd1;
        work_d = gen_key;
        if (rc_q == 4'(NUM_ROUNDS - 1)) begin
          state_d = READY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers: FSM state, rcon index and the key being expanded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rc_q    <= 4'd0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      work_q  <= work_d;
    end
  end

  // Key bank: slot 0 takes the cipher key, slot rc+1 takes keyGen(rc).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      if (load) begin
        bank_q[0] <= key_in;
      end
      for (int i = 1; i <= NUM_ROUNDS; i++) begin
        if (step && (rc_q == 4'(i - 1))) begin
          bank_q[i] <= gen_key;
        end
      end
    end
  end

  // Read select; indices beyond the last round key return zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (rd_round == 4'(i)) begin
        rd_mux = bank_q[i];
      end
    end
  end

  // Registered read port; samples the bank before this edge's write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_key_q <= '0;
    end else begin
      rd_key_q <= rd_mux;
    end
  end

  assign key_busy  = (state_q == EXPAND);
  assign key_ready = (state_q == READY);
  assign rd_key    = rd_key_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl using FIPS-197 key schedules.
// Latency: n/a.
// Backpressure: n/a.
module tb_aes_key_sched_ctrl;

  logic         clk;
  logic         rst;
  logic         key_start;
  logic [127:0] key_in;
  logic         key_busy;
  logic         key_ready;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;

  logic         key_start1;
  logic [127:0] key_in1;
  logic         key_busy1;
  logic         key_ready1;
  logic [3:0]   rd_round1;
  logic [127:0] rd_key1;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] exp_q[$];
  logic [127:0] KA [0:10];
  logic [127:0] KC0, KC1, KC2, KC10;

  aes_key_sched_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_start (key_start),
    .key_in    (key_in),
    .key_busy  (key_busy),
    .key_ready (key_ready),
    .rd_round  (rd_round),
    .rd_key    (rd_key)
  );

  aes_key_sched_ctrl #(.NUM_ROUNDS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .key_start (key_start1),
    .key_in    (key_in1),
    .key_busy  (key_busy1),
    .key_ready (key_ready1),
    .rd_round  (rd_round1),
    .rd_key    (rd_key1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish (got running, need finished)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a read address, queue its expected key, compare one cycle later.
  task automatic rd(input logic [3:0] idx, input logic [127:0] expv, input string tag);
    rd_round = idx;
    exp_q.push_back(expv);
    tick();
    chk($sformatf("%s_rd%0d", tag, idx), rd_key, exp_q.pop_front());
  endtask

  task automatic rd1(input logic [3:0] idx, input logic [127:0] expv);
    rd_round1 = idx;
    exp_q.push_back(expv);
    tick();
    chk($sformatf("nr1_rd%0d", idx), rd_key1, exp_q.pop_front());
  endtask

  // Pulse start, optionally fire a second start at a given cycle, count cycles to ready.
  task automatic run_expand(input logic [127:0] k, input int glitch_at, input string tag);
    int c;
    int busy_cnt;
    int both;
    key_in    = k;
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    key_in    = {4{32'hdeadbeef}};
    chk({tag, "_ready_drop"}, 128'(key_ready), 128'(0));
    c        = 0;
    busy_cnt = 0;
    both     = 0;
    while (!key_ready && c < 40) begin
      if (key_busy) busy_cnt++;
      if (c == glitch_at) begin
        key_in    = '0;
        key_start = 1'b1;
      end
      tick();
      key_start = 1'b0;
      if (key_busy && key_ready) both++;
      c++;
    end
    chk({tag, "_lat"}, 128'(c), 128'(10));
    chk({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(10));
    chk({tag, "_busy_at_ready"}, 128'(key_busy), 128'(0));
    chk({tag, "_busy_and_ready"}, 128'(both), 128'(0));
  endtask

  task automatic sweep_a(input string tag);
    for (int i = 0; i <= 10; i++) begin
      rd(4'(i), KA[i], tag);
    end
  endtask

  initial begin
    KA[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    KA[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    KA[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    KA[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    KA[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    KA[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    KA[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    KA[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    KA[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    KA[9]  = 128'hac7766f319fadc2128d12941575c006e;
    KA[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    KC0    = 128'h000102030405060708090a0b0c0d0e0f;
    KC1    = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    KC2    = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    KC10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    rst        = 1'b1;
    key_start  = 1'b0;
    key_in     = '0;
    rd_round   = 4'd0;
    key_start1 = 1'b0;
    key_in1    = '0;
    rd_round1  = 4'd0;
    tick();
    tick();
    chk("rst_busy", 128'(key_busy), 128'(0));
    chk("rst_ready", 128'(key_ready), 128'(0));
    chk("rst_rdkey", rd_key, 128'h0);
    rst = 1'b0;
    tick();
    rd(4'd0, 128'h0, "rst_bank");

    // FIPS-197 A.1 expansion and full read sweep, plus out-of-range reads.
    run_expand(KA[0], -1, "t1");
    sweep_a("t2");
    rd(4'd11, 128'h0, "t2");
    rd(4'd15, 128'h0, "t2");

    // Restart from READY with the C.1 key.
    run_expand(KC0, -1, "t4");
    rd(4'd0, KC0, "t4");
    rd(4'd1, KC1, "t4");
    rd(4'd2, KC2, "t4");
    rd(4'd10, KC10, "t4");

    // Second start mid-expansion must be ignored.
    run_expand(KA[0], 3, "t3");
    sweep_a("t3");

    // Reset in the middle of an expansion.
    key_in    = KA[0];
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    rd_round  = 4'd0;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_busy_before", 128'(key_busy), 128'(1));
    rst = 1'b1;
    #1;
    chk("t5_busy", 128'(key_busy), 128'(0));
    chk("t5_ready", 128'(key_ready), 128'(0));
    chk("t5_rdkey", rd_key, 128'h0);
    tick();
    rst = 1'b0;
    tick();
    rd(4'd0, 128'h0, "t5");
    rd(4'd10, 128'h0, "t5");
    chk("t5_ready_after", 128'(key_ready), 128'(0));
    run_expand(KA[0], -1, "t5r");
    sweep_a("t5r");

    // Single-round build.
    begin
      int c;
      int busy_cnt;
      key_in1    = KA[0];
      key_start1 = 1'b1;
      tick();
      key_start1 = 1'b0;
      c        = 0;
      busy_cnt = 0;
      while (!key_ready1 && c < 20) begin
        if (key_busy1) busy_cnt++;
        tick();
        c++;
      end
      chk("nr1_lat", 128'(c), 128'(1));
      chk("nr1_busy_cycles", 128'(busy_cnt), 128'(1));
      chk("nr1_busy_at_ready", 128'(key_busy1), 128'(0));
      rd1(4'd0, KA[0]);
      rd1(4'd1, KA[1]);
      rd1(4'd2, 128'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
